rr_reg_arbiter: RTL

- Round-robin arbiter and sequencer sharing one WIDTH-bit synchronous-reset register between 4 requesters.
- Selects one owner, loads that owner's data into the shared register, and acknowledges each transfer.
- Supports locked (burst) ownership, bounded by MAX_LOCK so no requester can starve the others.
- Sits between requester logic and the shared register; it is the only writer of that register.

---
 rtl/rr_reg_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rr_reg_arbiter.sv
// rtl/rr_reg_arbiter.sv - round-robin arbiter sequencing 4 requesters into one shared register
module rr_reg_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_LOCK = 4
) (
    input  logic                 clk,
    input  logic                 sync_reset_n,
    input  logic [3:0]           req,
    input  logic [3:0]           lock,
    input  logic [4*WIDTH-1:0]   wdata,
    output logic [3:0]           gnt,
    output logic [1:0]           gnt_id,
    output logic [3:0]           ack,
    output logic [WIDTH-1:0]     q,
    output logic                 q_valid,
    output logic                 busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;
    localparam logic [4:0] MAX_LOCK_C = 5'(MAX_LOCK);

    logic [0:0]       state_q,   state_d;
    logic [3:0]       gnt_q,     gnt_d;
    logic [1:0]       gnt_id_q,  gnt_id_d;
    logic [3:0]       ack_q,     ack_d;
    logic [WIDTH-1:0] q_q,       q_d;
    logic             q_valid_q, q_valid_d;
    logic [1:0]       ptr_q,     ptr_d;
    logic [3:0]       lcnt_q,    lcnt_d;

    logic [WIDTH-1:0] slice [4];
    logic [1:0]       owner;
    logic [4:0]       lcnt_inc;
    logic             keep;
    logic [3:0]       cand;
    logic [2:0]       pick;

    // Returns {found, index}: first set bit of cand scanning start, start+1, ... mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] c, input logic [1:0] start);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (c[idx]) begin
                r = {1'b1, idx};
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            slice[i] = wdata[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        ack_d     = 4'b0000;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        ptr_d     = ptr_q;
        lcnt_d    = lcnt_q;
        owner     = gnt_id_q;
        lcnt_inc  = {1'b0, lcnt_q} + 5'd1;
        keep      = 1'b0;
        cand      = req;
        pick      = 3'b000;

        case (state_q)
            ST_IDLE: begin
                pick = rr_pick(req, ptr_q);
                if (pick[2]) begin
                    state_d  = ST_OWN;
                    gnt_d    = 4'b0001 << pick[1:0];
                    gnt_id_d = pick[1:0];
                    lcnt_d   = 4'd0;
                end
            end
            ST_OWN: begin
                if (req[owner]) begin
                    q_d          = slice[owner];
                    q_valid_d    = 1'b1;
                    ack_d[owner] = 1'b1;
                    lcnt_d       = lcnt_inc[3:0];
                end
                keep = req[owner] && lock[owner] && (lcnt_inc < MAX_LOCK_C);
                if (!keep) begin
                    // The releasing owner is masked so others get a turn before it is re-granted.
                    ptr_d  = owner + 2'd1;
                    cand   = req & ~(4'b0001 << owner);
                    pick   = rr_pick(cand, owner + 2'd1);
                    lcnt_d = 4'd0;
                    if (pick[2]) begin
                        state_d  = ST_OWN;
                        gnt_d    = 4'b0001 << pick[1:0];
                        gnt_id_d = pick[1:0];
                    end else begin
                        state_d  = ST_IDLE;
                        gnt_d    = 4'b0000;
                        gnt_id_d = 2'd0;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_d    = 4'b0000;
                gnt_id_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 4'b0000;
            gnt_id_q  <= 2'd0;
            ack_q     <= 4'b0000;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            ptr_q     <= 2'd0;
            lcnt_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            ack_q     <= ack_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            ptr_q     <= ptr_d;
            lcnt_q    <= lcnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign ack     = ack_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign busy    = (state_q == ST_OWN);

endmodule
